// File: rtl/pla_cube_eval.sv
// Sum-of-products evaluator over N_CUBES runtime-programmable cubes, streamed through a 2-stage valid/ready pipeline.
// Define PLA_CUBE_EVAL_HITCNT_EN to add a saturating hit_cnt output that counts hitting output handshakes.
module pla_cube_eval #(
    parameter int N_IN    = 14,
    parameter int N_CUBES = 4,
    parameter int IDX_W   = (N_CUBES > 1) ? $clog2(N_CUBES) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [N_IN-1:0]  cfg_care,
    input  logic [N_IN-1:0]  cfg_val,
    input  logic             cfg_en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_y,
    output logic             out_hit,
    output logic [IDX_W-1:0] out_idx
`ifdef PLA_CUBE_EVAL_HITCNT_EN
    ,
    output logic [31:0]      hit_cnt
`endif
);

    logic [N_IN-1:0]    care_q [N_CUBES];
    logic [N_IN-1:0]    val_q  [N_CUBES];
    logic [N_CUBES-1:0] en_q;
    logic               cfg_ok;

    logic [N_CUBES-1:0] match;
    logic               s1_valid;
    logic [N_CUBES-1:0] s1_match;
    logic               s1_load;
    logic               enc_hit;
    logic [IDX_W-1:0]   enc_idx;
    logic               s2_valid;
    logic               s2_y;
    logic [IDX_W-1:0]   s2_idx;
    logic               s2_load;

    // Out-of-range indices exist whenever N_CUBES is not a power of two.
    assign cfg_ok = cfg_we && (int'(cfg_idx) < N_CUBES);

    // NOTE: the cube store is cleared by reset on purpose; a reset mid-stream must leave no stale product terms behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_CUBES; k++) begin
                care_q[k] <= '0;
                val_q[k]  <= '0;
            end
            en_q <= '0;
        end else if (cfg_ok) begin
            care_q[cfg_idx] <= cfg_care;
            val_q[cfg_idx]  <= cfg_val;
            en_q[cfg_idx]   <= cfg_en;
        end
    end

    // NOTE: every always_comb output gets a default before any conditional logic, so no latch can be inferred.
    always_comb begin
        match = '0;
        for (int k = 0; k < N_CUBES; k++) begin
            match[k] = en_q[k] && (((in_x ~^ val_q[k]) & care_q[k]) == care_q[k]);
        end
    end

    assign s2_load  = !s2_valid || out_ready;
    assign in_ready = !s1_valid || s2_load;
    assign s1_load  = in_valid && in_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_match <= '0;
        end else if (s1_load) begin
            s1_valid <= 1'b1;
            s1_match <= match;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    // Downward scan, so the lowest set bit is the last one written.
    always_comb begin
        enc_hit = |s1_match;
        enc_idx = '0;
        for (int k = N_CUBES - 1; k >= 0; k--) begin
            if (s1_match[k]) begin
                enc_idx = IDX_W'(k);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_y     <= 1'b0;
            s2_idx   <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            s2_y     <= s1_valid && enc_hit;
            s2_idx   <= s1_valid ? enc_idx : '0;
        end
    end

    assign out_valid = s2_valid;
    assign out_y     = s2_y;
    assign out_hit   = s2_y;
    assign out_idx   = s2_idx;

`ifdef PLA_CUBE_EVAL_HITCNT_EN
    // A cube write clears the count and takes priority over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt <= '0;
        end else if (cfg_ok) begin
            hit_cnt <= '0;
        end else if (s2_valid && out_ready && s2_y && (hit_cnt != 32'hFFFF_FFFF)) begin
            hit_cnt <= hit_cnt + 32'd1;
        end
    end
`else
    // Default build: no hit counter.
`endif

endmodule
